// File: rtl/mmio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_bus_ctrl
//   Memory-mapped bus controller between the processor data port and one RAM
//   plus N_PERIPH peripheral slots. Each access is decoded once and the chosen
//   target gets a held select (and write) strobe until it answers with ready
//   or the timeout expires. The CPU sees a one-cycle registered
//   ready/error/read-data response. An unmapped peripheral slot answers with
//   an error and never strobes anything.
//
//   Optional feature macro: BUS_ERR_LOG_EN
//     defined   -> err_addr / err_cnt hold the last failing address and a
//                  saturating error count; err_clr zeroes both.
//     undefined -> err_addr / err_cnt are constant zero, err_clr is ignored.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU request, held until cpu_ready
//   cpu_rdata/ready/err   registered one-cycle response
//   ram_sel/we, ram_rdata, ram_ready         RAM side
//   per_sel (one-hot), per_we, per_rdata (packed), per_ready  peripherals
//   per_wdata             write data broadcast to RAM and peripherals
//   err_clr, err_addr, err_cnt                error log
// ---------------------------------------------------------------------------
module mmio_bus_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_PERIPH = 6,
    parameter int RAM_BIT  = 8,
    parameter int SEL_LSB  = 2,
    parameter int SEL_W    = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic                         ram_sel,
    output logic                         ram_we,
    input  logic [DATA_W-1:0]            ram_rdata,
    input  logic                         ram_ready,
    output logic [N_PERIPH-1:0]          per_sel,
    output logic                         per_we,
    output logic [DATA_W-1:0]            per_wdata,
    input  logic [N_PERIPH*DATA_W-1:0]   per_rdata,
    input  logic [N_PERIPH-1:0]          per_ready,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [7:0]                   err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Counter wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int                TCNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0]    N_PERIPH_L = (SEL_W + 1)'(N_PERIPH);

    state_t              state_r;
    logic                tgt_ram_r;
    logic [SEL_W-1:0]    tgt_idx_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [TCNT_W-1:0]   tcnt_r;

    logic                req_ram_s;
    logic [SEL_W-1:0]    req_idx_s;
    logic                req_unmapped_s;
    logic                sel_ready_s;
    logic [DATA_W-1:0]   sel_rdata_s;

    // One-hot peripheral strobe for a slot index.
    function automatic logic [N_PERIPH-1:0] onehot_f(input logic [SEL_W-1:0] idx);
        logic [N_PERIPH-1:0] v;
        v = '0;
        for (int i = 0; i < N_PERIPH; i++) begin
            v[i] = (int'(idx) == i);
        end
        return v;
    endfunction

    // Address decode of the incoming request.
    always_comb begin
        req_ram_s = ~cpu_addr[RAM_BIT];
        req_idx_s = cpu_addr[SEL_LSB +: SEL_W];
        if (req_ram_s) begin
            req_unmapped_s = 1'b0;
        end else begin
            req_unmapped_s = ({1'b0, req_idx_s} >= N_PERIPH_L);
        end
    end

    // Ready and read data of the latched target only; other sources are masked.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rdata_s = '0;
        if (tgt_ram_r) begin
            sel_ready_s = ram_ready;
            sel_rdata_s = ram_rdata;
        end else begin
            for (int i = 0; i < N_PERIPH; i++) begin
                sel_ready_s = sel_ready_s | (per_ready[i] & (int'(tgt_idx_r) == i));
                sel_rdata_s = sel_rdata_s |
                              (per_rdata[i*DATA_W +: DATA_W] & {DATA_W{int'(tgt_idx_r) == i}});
            end
        end
    end

    // Access sequencer with registered strobes and CPU response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tgt_ram_r <= 1'b0;
            tgt_idx_r <= '0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            tcnt_r    <= '0;
            ram_sel   <= 1'b0;
            ram_we    <= 1'b0;
            per_sel   <= '0;
            per_we    <= 1'b0;
            per_wdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                    if (cpu_req) begin
                        addr_r    <= cpu_addr;
                        we_r      <= cpu_we;
                        per_wdata <= cpu_wdata;
                        tgt_ram_r <= req_ram_s;
                        tgt_idx_r <= req_idx_s;
                        tcnt_r    <= '0;
                        if (req_unmapped_s) begin
                            // No target exists: answer immediately, strobe nothing.
                            state_r   <= ST_RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                        end else if (req_ram_s) begin
                            state_r <= ST_ACCESS;
                            ram_sel <= 1'b1;
                            ram_we  <= cpu_we;
                        end else begin
                            state_r <= ST_ACCESS;
                            per_sel <= onehot_f(req_idx_s);
                            per_we  <= cpu_we;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_ACCESS: begin
                    // Ready is checked first so it wins over the timeout limit.
                    if (sel_ready_s) begin
                        state_r   <= ST_RESP;
                        ram_sel   <= 1'b0;
                        ram_we    <= 1'b0;
                        per_sel   <= '0;
                        per_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b0;
                        cpu_rdata <= we_r ? '0 : sel_rdata_s;
                    end else if (tcnt_r == TCNT_LAST) begin
                        state_r   <= ST_RESP;
                        ram_sel   <= 1'b0;
                        ram_we    <= 1'b0;
                        per_sel   <= '0;
                        per_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_W'(1);
                    end
                end

                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    ram_sel   <= 1'b0;
                    ram_we    <= 1'b0;
                    per_sel   <= '0;
                    per_we    <= 1'b0;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    ram_sel   <= 1'b0;
                    ram_we    <= 1'b0;
                    per_sel   <= '0;
                    per_we    <= 1'b0;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                end
            endcase
        end
    end

`ifdef BUS_ERR_LOG_EN
    // Error log: loads once per error response; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
            err_cnt  <= 8'd0;
        end else if (err_clr) begin
            err_addr <= '0;
            err_cnt  <= 8'd0;
        end else if ((state_r == ST_RESP) && cpu_err) begin
            err_addr <= addr_r;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end else begin
                err_cnt <= err_cnt;
            end
        end else begin
            err_addr <= err_addr;
            err_cnt  <= err_cnt;
        end
    end
`else
    assign err_addr = '0;
    assign err_cnt  = 8'd0;

    // The latched address only feeds the log; sink it with err_clr.
    logic unused_s;
    assign unused_s = ^{err_clr, addr_r};
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_bus_ctrl
//   Self-checking bench for mmio_bus_ctrl with default parameters.
//   A directed table, randomized transactions judged by a transaction-level
//   reference model, and hand sequences for reset, throughput and log clear.
// ---------------------------------------------------------------------------
module tb_mmio_bus_ctrl;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int N_PERIPH = 6;
    localparam int TIMEOUT  = 15;
`ifdef BUS_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic                       clk;
    logic                       rst_n;
    logic                       cpu_req;
    logic                       cpu_we;
    logic [ADDR_W-1:0]          cpu_addr;
    logic [DATA_W-1:0]          cpu_wdata;
    logic [DATA_W-1:0]          cpu_rdata;
    logic                       cpu_ready;
    logic                       cpu_err;
    logic                       ram_sel;
    logic                       ram_we;
    logic [DATA_W-1:0]          ram_rdata;
    logic                       ram_ready;
    logic [N_PERIPH-1:0]        per_sel;
    logic                       per_we;
    logic [DATA_W-1:0]          per_wdata;
    logic [N_PERIPH*DATA_W-1:0] per_rdata;
    logic [N_PERIPH-1:0]        per_ready;
    logic                       err_clr;
    logic [ADDR_W-1:0]          err_addr;
    logic [7:0]                 err_cnt;

    mmio_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .ram_sel(ram_sel), .ram_we(ram_we), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .per_sel(per_sel), .per_we(per_we), .per_wdata(per_wdata),
        .per_rdata(per_rdata), .per_ready(per_ready),
        .err_clr(err_clr), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat: strobe cycle (1-based) in which the target raises ready; 0 = never.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] data;
        bit          stray;
        bit          clr;
        bit          exp_err;
        int          exp_strobes;
        logic [31:0] exp_rdata;
    } vec_t;

    int          checks;
    int          failures;
    int          model_cnt;
    logic [31:0] model_addr;
    vec_t        tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                input int lat, input logic [31:0] data, input bit stray, input bit clr,
                                input bit e_err, input int e_str, input logic [31:0] e_rd);
        vec_t v;
        v.addr = addr; v.we = we; v.wdata = wdata; v.lat = lat; v.data = data;
        v.stray = stray; v.clr = clr;
        v.exp_err = e_err; v.exp_strobes = e_str; v.exp_rdata = e_rd;
        return v;
    endfunction

    // Reference model: outcome of one access from the address map and timing rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   is_ram;
        int   idx;
        r      = v;
        is_ram = (v.addr[8] == 1'b0);
        idx    = int'(v.addr[4:2]);
        if (!is_ram && idx >= N_PERIPH) begin
            r.exp_err = 1'b1; r.exp_strobes = 0;
        end else if (v.lat < 1 || v.lat > TIMEOUT) begin
            r.exp_err = 1'b1; r.exp_strobes = TIMEOUT;
        end else begin
            r.exp_err = 1'b0; r.exp_strobes = v.lat;
        end
        r.exp_rdata = (r.exp_err || v.we) ? 32'h0 : v.data;
        return r;
    endfunction

    // Drive one access from an idle cycle, play the target, check the outcome.
    task automatic run_txn(input vec_t v, input string name);
        bit                         is_ram;
        int                         idx;
        int                         strobes;
        bit                         got;
        bit                         shape_ok;
        logic [N_PERIPH-1:0]        exp_sel;
        logic [N_PERIPH*DATA_W-1:0] pr;
        is_ram  = (v.addr[8] == 1'b0);
        idx     = int'(v.addr[4:2]);
        exp_sel = '0;
        if (!is_ram && idx < N_PERIPH) exp_sel[idx] = 1'b1;
        for (int i = 0; i < N_PERIPH; i++)
            pr[i*DATA_W +: DATA_W] = (!is_ram && i == idx) ? v.data : $urandom;
        per_rdata = pr;
        ram_rdata = is_ram ? v.data : $urandom;
        cpu_addr  = v.addr; cpu_we = v.we; cpu_wdata = v.wdata; cpu_req = 1'b1;
        err_clr   = v.clr;
        strobes = 0; got = 1'b0; shape_ok = 1'b1;
        for (int n = 1; n <= TIMEOUT + 10; n++) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                got = 1'b1;
                check({name, "/strobes"}, 64'(strobes), 64'(v.exp_strobes));
                check({name, "/err"}, 64'(cpu_err), 64'(v.exp_err));
                check({name, "/rdata"}, 64'(cpu_rdata), 64'(v.exp_rdata));
                check({name, "/resp_bus_idle"}, 64'({ram_sel, ram_we, per_sel, per_we}), 64'd0);
                cpu_req = 1'b0; ram_ready = 1'b0; per_ready = '0;
                break;
            end
            strobes++;
            if (is_ram) begin
                if (!(ram_sel === 1'b1 && ram_we === v.we && per_sel === '0 && per_we === 1'b0))
                    shape_ok = 1'b0;
            end else begin
                if (!(ram_sel === 1'b0 && ram_we === 1'b0 && per_sel === exp_sel && per_we === v.we))
                    shape_ok = 1'b0;
            end
            if (per_wdata !== v.wdata) shape_ok = 1'b0;
            ram_ready = (v.stray && !is_ram) ? 1'($urandom_range(0, 1)) : 1'b0;
            per_ready = v.stray ? (N_PERIPH'($urandom) & ~exp_sel) : '0;
            if (strobes == v.lat) begin
                if (is_ram) ram_ready = 1'b1;
                else if (idx < N_PERIPH) per_ready[idx] = 1'b1;
            end
        end
        if (!got) begin
            check({name, "/response_seen"}, 64'd0, 64'd1);
            cpu_req = 1'b0; ram_ready = 1'b0; per_ready = '0;
        end
        check({name, "/strobe_shape"}, 64'(shape_ok), 64'd1);
        if (LOG_EN) begin
            if (v.exp_err) begin
                model_addr = v.addr;
                if (model_cnt < 255) model_cnt++;
            end
            if (v.clr) begin
                model_addr = 32'h0; model_cnt = 0;
            end
        end
        @(negedge clk);
        check({name, "/err_cnt"}, 64'(err_cnt), 64'(model_cnt));
        check({name, "/err_addr"}, 64'(err_addr), 64'(model_addr));
        err_clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rdy_mask;
        logic [8:0] sel_mask;
        vec_t       v;
        checks = 0; failures = 0; model_cnt = 0; model_addr = 32'h0;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ram_rdata = 32'h0; ram_ready = 1'b0; per_rdata = '0; per_ready = '0; err_clr = 1'b0;

        //                addr          we    wdata         lat data          str  clr  err str rdata
        tbl[0]  = mk(32'h0000_0010, 1'b1, 32'hA5A5_A5A5,  1, 32'h0000_0000, 1'b0, 1'b0, 1'b0,  1, 32'h0);
        tbl[1]  = mk(32'h0000_010C, 1'b0, 32'h0000_0000,  4, 32'h0000_1234, 1'b0, 1'b0, 1'b0,  4, 32'h0000_1234);
        tbl[2]  = mk(32'h0000_0118, 1'b0, 32'h0000_0000,  1, 32'h0000_7777, 1'b0, 1'b0, 1'b1,  0, 32'h0);
        tbl[3]  = mk(32'h0000_0104, 1'b0, 32'h0000_0000,  0, 32'h0000_9999, 1'b0, 1'b0, 1'b1, 15, 32'h0);
        tbl[4]  = mk(32'h0000_0108, 1'b0, 32'h0000_0000,  3, 32'hCAFE_0002, 1'b1, 1'b0, 1'b0,  3, 32'hCAFE_0002);
        tbl[5]  = mk(32'h0000_0114, 1'b0, 32'h0000_0000, 15, 32'h0000_55AA, 1'b1, 1'b0, 1'b0, 15, 32'h0000_55AA);
        tbl[6]  = mk(32'h0000_0000, 1'b0, 32'h0000_0000, 16, 32'h1357_9BDF, 1'b0, 1'b0, 1'b1, 15, 32'h0);
        tbl[7]  = mk(32'h0000_00FC, 1'b0, 32'h0000_0000,  2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0,  2, 32'hDEAD_BEEF);
        tbl[8]  = mk(32'h0000_0100, 1'b1, 32'h1122_3344,  1, 32'h6666_6666, 1'b0, 1'b0, 1'b0,  1, 32'h0);
        tbl[9]  = mk(32'h0000_011C, 1'b1, 32'h0BAD_0BAD,  1, 32'h0000_0000, 1'b0, 1'b0, 1'b1,  0, 32'h0);
        tbl[10] = mk(32'h0000_0118, 1'b0, 32'h0000_0000,  1, 32'h0000_0000, 1'b0, 1'b1, 1'b1,  0, 32'h0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset/cpu_resp", 64'({cpu_ready, cpu_err, cpu_rdata}), 64'd0);
        check("reset/strobes", 64'({ram_sel, ram_we, per_sel, per_we}), 64'd0);
        check("reset/per_wdata", 64'(per_wdata), 64'd0);
        check("reset/err_log", 64'({err_cnt, err_addr}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            v.addr  = $urandom;
            v.we    = 1'($urandom_range(0, 1));
            v.wdata = $urandom;
            v.lat   = $urandom_range(0, TIMEOUT + 2);
            v.data  = $urandom;
            v.stray = 1'($urandom_range(0, 1));
            v.clr   = ($urandom_range(0, 9) == 0);
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        // Back-to-back RAM writes with req held: one access per 3 cycles.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h0F0F_0F0F;
        ram_ready = 1'b1;
        rdy_mask = '0; sel_mask = '0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            rdy_mask[n-1] = cpu_ready;
            sel_mask[n-1] = ram_sel;
            if (n == 8) cpu_req = 1'b0;
        end
        ram_ready = 1'b0;
        check("b2b/cpu_ready_pattern", 64'(rdy_mask), 64'(9'b010010010));
        check("b2b/ram_sel_pattern", 64'(sel_mask), 64'(9'b001001001));

        // Stand-alone log clear from idle.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        if (LOG_EN) begin
            model_cnt = 0; model_addr = 32'h0;
        end
        check("clr/err_cnt", 64'(err_cnt), 64'(model_cnt));
        check("clr/err_addr", 64'(err_addr), 64'(model_addr));

        // Error count saturation through repeated unmapped accesses.
        for (int i = 0; i < 258; i++) begin
            v.addr  = {$urandom} & 32'hFFFF_FEE3;
            v.addr  = v.addr | 32'h0000_0100 | (32'($urandom_range(6, 7)) << 2);
            v.we    = 1'($urandom_range(0, 1));
            v.wdata = $urandom; v.lat = 1; v.data = $urandom; v.stray = 1'b0; v.clr = 1'b0;
            run_txn(model(v), $sformatf("sat%0d", i));
        end

        // Reset in the middle of an access to slot 1.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
        repeat (3) @(negedge clk);
        check("midrst/strobe_active", 64'(per_sel), 64'(6'b000010));
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        check("midrst/strobes_dropped", 64'({ram_sel, ram_we, per_sel, per_we}), 64'd0);
        check("midrst/no_resp", 64'({cpu_ready, cpu_err}), 64'd0);
        model_cnt = 0; model_addr = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst/still_no_resp", 64'(cpu_ready), 64'd0);
        check("midrst/log_cleared", 64'({err_cnt, err_addr}), 64'd0);
        run_txn(tbl[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
